// File: rtl/sec_timer_pkg.sv
// rtl/sec_timer_pkg.sv - shared state encoding, BCD widths and clamp helpers for the seconds timer
package sec_timer_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_W       = 2 * BCD_DIGIT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [BCD_DIGIT_W-1:0] clamp_digit(input logic [BCD_DIGIT_W-1:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] v);
        return {clamp_digit(v[7:4]), clamp_digit(v[3:0])};
    endfunction

endpackage

// File: rtl/sec_timer_bcd_down_digit.sv
// rtl/sec_timer_bcd_down_digit.sv - one decimal down-counting digit with load and borrow-out
module bcd_down_digit
    import sec_timer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_dec,
    input  logic                   i_load,
    input  logic [BCD_DIGIT_W-1:0] i_load_val,
    output logic [BCD_DIGIT_W-1:0] o_digit,
    output logic                   o_borrow
);

    logic [BCD_DIGIT_W-1:0] r_digit;

    // Load has priority so a reload never races a decrement of the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_digit <= '0;
        end else if (i_load) begin
            r_digit <= clamp_digit(i_load_val);
        end else if (i_dec) begin
            r_digit <= (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
        end
    end

    assign o_borrow = i_dec && (r_digit == 4'd0);
    assign o_digit  = r_digit;

endmodule

// File: rtl/sec_timer.sv
// rtl/sec_timer.sv - two-digit BCD seconds countdown timer with run/hold/abort and optional auto-reload
module sec_timer
    import sec_timer_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             sw,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] sec_bcd,
    output logic             busy,
    output logic             done,
    output logic             alarm
);

    state_t           r_state;
    logic [BCD_W-1:0] r_reload;
    logic             r_start_d;
    logic             r_busy;
    logic             r_done;
    logic             r_alarm;

    logic                   w_start_rise;
    logic                   w_load_ok;
    logic                   w_reload;
    logic                   w_dec;
    logic                   w_hit_zero;
    logic                   w_underflow;
    logic                   w_ld_en;
    logic [BCD_W-1:0]       w_ld_val;
    logic [BCD_W-1:0]       w_sec;
    logic [BCD_DIGIT_W-1:0] w_ones;
    logic [BCD_DIGIT_W-1:0] w_tens;
    logic                   w_ones_borrow;

    assign w_start_rise = start && !r_start_d;
    assign w_load_ok    = load && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_reload     = AUTO_RELOAD && (r_state == ST_DONE) && start;
    // Abort (start=0) and hold (sw=1) both outrank a coincident tick.
    assign w_dec        = (r_state == ST_RUN) && start && !sw && tick;
    assign w_hit_zero   = w_dec && (w_sec == 8'h01);
    assign w_ld_en      = w_load_ok || w_reload;
    assign w_ld_val     = w_load_ok ? load_val : r_reload;
    assign w_sec        = {w_tens, w_ones};

    bcd_down_digit u_ones (
        .clk        (clk),
        .rst        (rst),
        .i_dec      (w_dec),
        .i_load     (w_ld_en),
        .i_load_val (w_ld_val[3:0]),
        .o_digit    (w_ones),
        .o_borrow   (w_ones_borrow)
    );

    bcd_down_digit u_tens (
        .clk        (clk),
        .rst        (rst),
        .i_dec      (w_ones_borrow),
        .i_load     (w_ld_en),
        .i_load_val (w_ld_val[7:4]),
        .o_digit    (w_tens),
        .o_borrow   (w_underflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_reload  <= '0;
            r_start_d <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_start_d <= start;
            r_done    <= 1'b0;
            if (w_load_ok) begin
                r_reload <= clamp_bcd(load_val);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise && !sw && (w_sec != 8'h00)) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!start) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (sw) begin
                        r_state <= ST_HOLD;
                    end else if (w_hit_zero || w_underflow) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_alarm <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!start) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!sw) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        r_state <= ST_IDLE;
                        r_alarm <= 1'b0;
                    end else if (AUTO_RELOAD) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_alarm <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_alarm <= 1'b0;
                end
            endcase
        end
    end

    assign sec_bcd = w_sec;
    assign busy    = r_busy;
    assign done    = r_done;
    assign alarm   = r_alarm;

endmodule

// File: tb/tb_sec_timer.sv
// tb/tb_sec_timer.sv - randomized model-checked bench for sec_timer, both reload modes
module tb_sec_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       sw = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [7:0] sec_o [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic       alarm_o [2];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #4 clk = ~clk;

    sec_timer #(.AUTO_RELOAD(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .sw(sw), .load(load),
        .load_val(load_val), .sec_bcd(sec_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .alarm(alarm_o[0])
    );

    sec_timer #(.AUTO_RELOAD(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .sw(sw), .load(load),
        .load_val(load_val), .sec_bcd(sec_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .alarm(alarm_o[1])
    );

    // Model: count held as a plain integer of seconds, modes as flags.
    int m_cnt [2];
    int m_rl [2];
    bit m_counting [2];
    bit m_paused [2];
    bit m_ringing [2];
    bit m_pulse [2];
    bit m_prev;

    function automatic int bcd_to_int(input logic [7:0] v);
        int t;
        int o;
        t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        o = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return t * 10 + o;
    endfunction

    function automatic logic [7:0] int_to_bcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    task automatic model_step(input int i, input bit rise);
        bit go;
        m_pulse[i] = 1'b0;
        if (m_ringing[i]) begin
            if (load) begin
                m_cnt[i] = bcd_to_int(load_val);
                m_rl[i]  = m_cnt[i];
            end else if (i == 1 && start) begin
                m_cnt[i] = m_rl[i];
            end
            if (!start) m_ringing[i] = 1'b0;
            else if (i == 1) begin
                m_ringing[i]  = 1'b0;
                m_counting[i] = 1'b1;
                m_paused[i]   = 1'b0;
            end
        end else if (!m_counting[i]) begin
            go = rise && !sw && (m_cnt[i] != 0);
            if (load) begin
                m_cnt[i] = bcd_to_int(load_val);
                m_rl[i]  = m_cnt[i];
            end
            if (go) begin
                m_counting[i] = 1'b1;
                m_paused[i]   = 1'b0;
            end
        end else begin
            if (!start) m_counting[i] = 1'b0;
            else if (m_paused[i]) begin
                if (!sw) m_paused[i] = 1'b0;
            end else if (sw) m_paused[i] = 1'b1;
            else if (tick) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) begin
                    m_pulse[i]    = 1'b1;
                    m_counting[i] = 1'b0;
                    m_ringing[i]  = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_rl[i] = 0; m_counting[i] = 0;
                m_paused[i] = 0; m_ringing[i] = 0; m_pulse[i] = 0;
            end
            m_prev = 1'b0;
        end else begin
            bit rise;
            rise = start && !m_prev;
            for (int i = 0; i < 2; i++) model_step(i, rise);
            m_prev = start;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_sec[%0d]", i), int'(sec_o[i]), int'(int_to_bcd(m_cnt[i])));
                chk($sformatf("model_busy[%0d]", i), int'(busy_o[i]), int'(m_counting[i]));
                chk($sformatf("model_done[%0d]", i), int'(done_o[i]), int'(m_pulse[i]));
                chk($sformatf("model_alarm[%0d]", i), int'(alarm_o[i]), int'(m_ringing[i]));
            end
        end
    end

    task automatic cyc(input bit s, input bit w, input bit t, input bit l, input logic [7:0] lv);
        start = s; sw = w; tick = t; load = l; load_val = lv;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_a [3];
        bit s;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_sec", int'(sec_o[0]), 8'h00);
        chk("rst_busy", int'(busy_o[0]), 0);
        chk("rst_alarm", int'(alarm_o[0]), 0);

        // load 12, run, three ticks
        cyc(0, 0, 0, 1, 8'h12);
        chk("load12", int'(sec_o[0]), 8'h12);
        cyc(1, 0, 0, 0, 8'h00);
        chk("run_busy", int'(busy_o[0]), 1);
        exp_a = '{8'h11, 8'h10, 8'h09};
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 1, 0, 8'h00);
            chk("tick_seq", int'(sec_o[0]), int'(exp_a[k]));
        end
        chk("tick_busy", int'(busy_o[0]), 1);

        // load 02, run to zero
        cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h02);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 0, 8'h00);
        chk("cnt01", int'(sec_o[0]), 8'h01);
        cyc(1, 0, 1, 0, 8'h00);
        chk("zero_sec", int'(sec_o[0]), 8'h00);
        chk("zero_done", int'(done_o[0]), 1);
        chk("zero_alarm", int'(alarm_o[0]), 1);
        chk("ar_done", int'(done_o[1]), 1);
        cyc(1, 0, 0, 0, 8'h00);
        chk("done_1cyc", int'(done_o[0]), 0);
        chk("alarm_hold", int'(alarm_o[0]), 1);
        chk("ar_reload_sec", int'(sec_o[1]), 8'h02);
        chk("ar_reload_busy", int'(busy_o[1]), 1);
        cyc(0, 0, 0, 0, 8'h00);
        chk("alarm_clear", int'(alarm_o[0]), 0);

        // hold wins over a coincident tick
        cyc(0, 0, 0, 1, 8'h07);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h00);
        for (int k = 0; k < 5; k++) cyc(1, 1, 1, 0, 8'h00);
        chk("hold_sec", int'(sec_o[0]), 8'h07);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 0, 8'h00);
        chk("resume_sec", int'(sec_o[0]), 8'h06);

        // clamp and load-ignored-in-run
        cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'hAF);
        chk("clamp_sec", int'(sec_o[0]), 8'h99);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 1, 8'h33);
        chk("run_load_ign", int'(sec_o[0]), 8'h99);
        cyc(1, 0, 1, 0, 8'h00);
        chk("dec99", int'(sec_o[0]), 8'h98);

        // reset mid-run
        cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h45);
        cyc(1, 0, 0, 0, 8'h00);
        chk("pre_rst_sec", int'(sec_o[0]), 8'h45);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_sec", int'(sec_o[0]), 8'h00);
        chk("async_rst_busy", int'(busy_o[0]), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 0, 1, 0, 8'h00);
        chk("post_rst_idle", int'(busy_o[0]), 0);

        // randomized phase
        s = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 11) == 0) s = !s;
            if ($urandom_range(0, 599) == 0) begin
                start = s;
                do_reset();
            end else begin
                cyc(s, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 9) == 0, 8'($urandom));
            end
        end
        cyc(0, 0, 0, 0, 8'h00);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sec_timer.md
SEC_TIMER -- requirements
Module: sec_timer

Interface
REQ-001 SHALL have parameter AUTO_RELOAD, default 0; when 1, DONE reloads the last loaded value and resumes counting.
REQ-002 SHALL have port clk, input, 1, 125 MHz system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset; one clock, no other clock domains.
REQ-004 SHALL have port tick, input, 1, one-cycle 1 Hz pulse from the divider, synchronous to clk.
REQ-005 SHALL have port start, input, 1, level run-enable switch, synchronous.
REQ-006 SHALL have port sw, input, 1, level hold switch; 1 freezes the count.
REQ-007 SHALL have port load, input, 1, one-cycle pulse that captures load_val.
REQ-008 SHALL have port load_val, input, 8, two-digit packed BCD seconds, tens in [7:4].
REQ-009 SHALL have port sec_bcd, output, 8, current count, packed BCD.
REQ-010 SHALL have port busy, output, 1, high in RUN or HOLD.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when the count reaches 00.
REQ-012 SHALL have port alarm, output, 1, level, high in DONE.

Function
REQ-013 SHALL implement states IDLE, RUN, HOLD, DONE; all outputs registered.
REQ-014 SHALL register start each cycle and detect its rising edge (start=1, previous start=0).
REQ-015 IDLE: SHALL go to RUN on a start rising edge with sw=0 and sec_bcd!=8'h00; otherwise SHALL stay in IDLE.
REQ-016 load in IDLE or DONE SHALL write load_val to sec_bcd and the reload register on the next edge; each digit >9 SHALL clamp to 9.
REQ-017 load in RUN or HOLD SHALL be ignored.
REQ-018 RUN, tick=1, sw=0, start=1: SHALL decrement sec_bcd by one BCD step, visible 1 cycle after tick is sampled.
REQ-019 BCD decrement: ones 0 SHALL wrap to 9 with tens-1; binary values A-F SHALL never appear on sec_bcd.
REQ-020 RUN, decrement from 8'h01 to 8'h00: SHALL pulse done for exactly 1 cycle, coincident with sec_bcd=8'h00, and enter DONE.
REQ-021 RUN with sw=1: SHALL go to HOLD; a tick in the same cycle SHALL be ignored (sw wins).
REQ-022 HOLD: ticks SHALL be ignored; sw=0 with start=1 SHALL return to RUN; sec_bcd SHALL be unchanged across HOLD.
REQ-023 RUN or HOLD with start=0: SHALL abort to IDLE and retain sec_bcd; abort SHALL win over a simultaneous tick.
REQ-024 DONE, AUTO_RELOAD=0: SHALL hold alarm=1 and go to IDLE when start=0.
REQ-025 DONE, AUTO_RELOAD=1, start=1: SHALL reload sec_bcd from the reload register and return to RUN on the next edge; start=0 SHALL go to IDLE.
REQ-026 A tick held high for multiple cycles SHALL decrement once per cycle; no pulse stretching is required upstream.

Reset
REQ-027 rst=0 SHALL asynchronously force: state IDLE, sec_bcd=8'h00, reload register=8'h00, busy=0, done=0, alarm=0, start history=0.
REQ-028 Reset mid-RUN SHALL discard the count; after release, a new start rising edge SHALL be required to run.

Structure
REQ-029 The state encoding (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3) and BCD width constants SHALL live in a shared timer package.
REQ-030 SHALL instantiate one sub-module, bcd_down_digit, twice: one decimal digit with decrement enable, load, and a borrow-out used as the tens enable.

Verification
REQ-031 load_val=8'h12, start rises with sw=0, 3 ticks -> sec_bcd 12,11,10,09; busy=1.
REQ-032 load_val=8'h02, run, 2 ticks -> sec_bcd 00, done high 1 cycle, alarm=1; start=0 -> IDLE, alarm=0.
REQ-033 Count at 8'h07, sw=1 in the same cycle as a tick -> stays 07 through 5 ticks; sw=0 -> next tick gives 06.
REQ-034 load_val=8'hAF -> sec_bcd=8'h99; a load pulse during RUN is ignored.
REQ-035 AUTO_RELOAD=1, load 8'h03, run to 00 -> done pulse, sec_bcd=03 on the next cycle, RUN resumes.
REQ-036 rst=0 mid-RUN at 8'h45 -> immediately sec_bcd=00, IDLE; start held high after release -> remains in IDLE.
